mem_port_arbiter: RTL

Shares one single-ported synchronous memory between the core's instruction-fetch path and its load/store path. Each cycle it picks one requester, drives the memory port from that requester, and tags the access. It returns read data and write acknowledges to the owner exactly `MEM_LAT` cycles later. The block sits between `riscv_core` and the unified memory, replacing separate instruction and data memories.

---
 rtl/mem_arb_pkg.sv | 14 +
 rtl/mem_port_arbiter_resp_pipe.sv | 31 +++
 rtl/mem_port_arbiter.sv | 108 ++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types for the memory port arbiter: owner encoding, response tag, latency bound.
// Arbitration mode is selected in the top by MEM_ARB_RR_EN.
package mem_arb_pkg;

  typedef enum logic {OWN_IF, OWN_D} owner_e;

  localparam int MEM_LAT_MAX = 4;

  typedef struct packed {
    logic   valid;
    owner_e owner;
  } resp_tag_t;

endpackage

// File: rtl/mem_port_arbiter_resp_pipe.sv
// Tag shift register: carries {valid, owner} of each accepted access until its data returns.
// Depth equals the memory read latency; a synchronous clear drops everything in flight.
module arb_resp_pipe
  import mem_arb_pkg::*;
#(
  parameter int MEM_LAT = 1
) (
  input  logic      clk,
  input  logic      clear,
  input  resp_tag_t tag_in,
  output resp_tag_t tag_out
);

  // Out-of-range latencies are clamped to the supported window.
  localparam int DEPTH = (MEM_LAT < 1) ? 1 :
                         (MEM_LAT > MEM_LAT_MAX) ? MEM_LAT_MAX : MEM_LAT;

  resp_tag_t stage [DEPTH];

  always_ff @(posedge clk) begin
    if (clear) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
    end else begin
      stage[0] <= tag_in;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign tag_out = stage[DEPTH-1];

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported synchronous memory between instruction fetch and load/store.
// Default: fixed data priority with a fetch starvation guard; MEM_ARB_RR_EN selects round-robin.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_gnt,
  output logic                if_rvalid,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [DATA_W/8-1:0] d_be,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic                d_gnt,
  output logic                d_rvalid,
  output logic [DATA_W-1:0]   d_rdata,
  input  logic                mem_ready,
  output logic                mem_req,
  output logic                mem_we,
  output logic [DATA_W/8-1:0] mem_be,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata
);

  // Handshake: a requester holds req (and its attributes) until it sees gnt; an access is
  // accepted in a cycle with req && gnt. gnt needs mem_ready, and at most one gnt is high.
  // The response (rvalid) arrives exactly MEM_LAT cycles after acceptance.

  logic      if_pri;
  logic      if_win;
  logic      d_win;
  resp_tag_t new_tag;
  resp_tag_t tail;

`ifdef MEM_ARB_RR_EN
  owner_e last_owner;

  always_ff @(posedge clk) begin
    if (reset)       last_owner <= OWN_IF;
    else if (if_gnt) last_owner <= OWN_IF;
    else if (d_gnt)  last_owner <= OWN_D;
  end

  assign if_pri = (last_owner == OWN_D);
`else
  localparam int SW = $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_MAX);

  logic [SW-1:0] starve_cnt;

  // Counts cycles the memory was free but fetch lost; a full count hands fetch the next contest.
  always_ff @(posedge clk) begin
    if (reset || !if_req || if_gnt)
      starve_cnt <= '0;
    else if (mem_ready && starve_cnt != STARVE_TOP)
      starve_cnt <= starve_cnt + 1'b1;
  end

  assign if_pri = (starve_cnt == STARVE_TOP);
`endif

  assign d_win  = d_req && !(if_req && if_pri);
  assign if_win = if_req && !d_win;
  assign d_gnt  = d_win  && mem_ready && !reset;
  assign if_gnt = if_win && mem_ready && !reset;

  always_comb begin
    mem_req   = if_gnt | d_gnt;
    mem_we    = 1'b0;
    mem_be    = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (d_gnt) begin
      mem_we    = d_we;
      mem_be    = d_be;
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
    end else if (if_gnt) begin
      mem_be    = '1;
      mem_addr  = if_addr;
    end
  end

  assign new_tag = '{valid: (if_gnt | d_gnt), owner: (d_gnt ? OWN_D : OWN_IF)};

  arb_resp_pipe #(.MEM_LAT(MEM_LAT)) u_resp_pipe (
    .clk     (clk),
    .clear   (reset),
    .tag_in  (new_tag),
    .tag_out (tail)
  );

  assign if_rvalid = tail.valid && (tail.owner == OWN_IF) && !reset;
  assign d_rvalid  = tail.valid && (tail.owner == OWN_D)  && !reset;
  assign if_rdata  = mem_rdata;
  assign d_rdata   = mem_rdata;

endmodule
